// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM among NUM_REQ requesters. Requester 0
//   (pixel display path) always wins; requesters 1..NUM_REQ-1 rotate
//   round-robin. Each granted read is tagged with its requester ID and comes
//   back two rising edges after the grant.
//
// Ports
//   vga_clk      : single clock; the ROM itself is clocked on ~vga_clk
//   reset_n      : asynchronous active-low reset
//   req          : per-requester level request, held until granted
//   req_addr     : packed request addresses, slice i = requester i
//   gnt          : one-hot combinational grant (not gated by reset)
//   rom_address  : registered ROM address
//   rom_q        : ROM read data
//   rsp_valid    : one-cycle pulse marking rsp_id / rsp_data valid
//   rsp_id       : requester owning the response
//   rsp_data     : palette index read from the ROM
//   idle         : no request pending and no read issued
//   stat_clr     : synchronous clear of stall_count      (stats build only)
//   stall_count  : saturating count of stalled cycles     (stats build only)
//
// Build option
//   SPRITE_ARB_STATS_EN : adds stat_clr / stall_count.

module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 5,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
`ifdef SPRITE_ARB_STATS_EN
    output logic                      idle,
    input  logic                      stat_clr,
    output logic [15:0]               stall_count
`else
    output logic                      idle
`endif
);

    logic [ID_W-1:0]   rr_ptr;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic              iss_v;
    logic [ID_W-1:0]   iss_id;

    // Requester 0 preempts everything. Otherwise scan 1..NUM_REQ-1 starting
    // at rr_ptr; the candidate index wraps from NUM_REQ back to 1, never to 0.
    always_comb begin
        int cand;
        cand     = 0;
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt_addr = '0;
        if (req[0]) begin
            gnt[0]   = 1'b1;
            gnt_any  = 1'b1;
            gnt_addr = req_addr[ADDR_W-1:0];
        end else begin
            for (int off = 0; off < NUM_REQ - 1; off++) begin
                cand = int'(rr_ptr) + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - (NUM_REQ - 1);
                end
                if (!gnt_any && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_any   = 1'b1;
                    gnt_id    = ID_W'(cand);
                    gnt_addr  = req_addr[cand*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // The pointer only advances on a round-robin grant, so display traffic
    // does not disturb the rotation among the sprite engines.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= ID_W'(1);
        end else if (gnt_any && !req[0]) begin
            if (gnt_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= ID_W'(1);
            end else begin
                rr_ptr <= gnt_id + ID_W'(1);
            end
        end
    end

    // Issue stage: the address holds when nothing is granted so the ROM
    // keeps seeing a stable value.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            iss_v       <= 1'b0;
            iss_id      <= '0;
        end else begin
            iss_v  <= gnt_any;
            iss_id <= gnt_id;
            if (gnt_any) begin
                rom_address <= gnt_addr;
            end
        end
    end

    // Response stage: the ROM sampled rom_address on the falling edge in
    // between, so rom_q already belongs to the issued read.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= iss_v;
            rsp_id    <= iss_id;
            rsp_data  <= rom_q;
        end
    end

    assign idle = ~|req & ~iss_v;

`ifdef SPRITE_ARB_STATS_EN
    // A cycle counts as stalled when any requester is left waiting,
    // including sprite engines locked out by the display path.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (|(req & ~gnt) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Self-checking bench for sprite_rom_arbiter: a fixed grant table, directed
//   multi-cycle sequences and a randomized run, all compared against a
//   scoreboard of expected responses and a priority/round-robin grant model.
//   Define SPRITE_ARB_STATS_EN to also exercise the stall counter.

module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 5;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                      vga_clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      idle;
    logic                      stat_clr;
    logic [15:0]               stall_count;

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
`ifdef SPRITE_ARB_STATS_EN
        .idle        (idle),
        .stat_clr    (stat_clr),
        .stall_count (stall_count)
`else
        .idle        (idle)
`endif
    );

`ifndef SPRITE_ARB_STATS_EN
    assign stall_count = 16'h0;
`endif

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ROM contents and a falling-edge ROM, as in the real sprite ROM
    logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
    always @(negedge vga_clk) rom_q <= rom_mem[rom_address];

    // Scoreboard of expected responses, each due on a given cycle
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [NUM_REQ-1:0] exp_gnt;
    } vec_t;
    vec_t tbl[13];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_seen = 0;
    int m_ptr = 1;
    int m_last_addr = 0;
    int m_stall = 0;
    logic [NUM_REQ-1:0] m_last_gnt = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [NUM_REQ*ADDR_W-1:0] packAddr(input int a0, input int a1,
                                                          input int a2, input int a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    // Display first; otherwise the first requester in the rotation order
    // ptr, ptr+1, ... taken over 1..NUM_REQ-1.
    function automatic int modelGrant(input logic [NUM_REQ-1:0] r, input int ptr);
        if (r[0]) return 0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            int c;
            c = ((ptr - 1 + k) % (NUM_REQ - 1)) + 1;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One bus cycle: drive after the rising edge, check on the falling edge,
    // then advance the reference model.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                                 input logic [NUM_REQ*ADDR_W-1:0] a,
                                 input logic clr);
        int g;
        int ga;
        logic [NUM_REQ-1:0] g1h;
        @(posedge vga_clk);
        #1;
        req      = r;
        req_addr = a;
        stat_clr = clr;
        cyc++;
        @(negedge vga_clk);
        g   = modelGrant(r, m_ptr);
        g1h = (g >= 0) ? NUM_REQ'(1 << g) : '0;
        checkOutput("gnt", gnt, g1h);
        checkOutput("rom_address", rom_address, m_last_addr);
        if (r != '0) begin
            checkOutput("idle_busy", idle, 0);
        end else if (sb.size() == 0) begin
            checkOutput("idle_quiet", idle, 1);
        end
        if (rsp_valid === 1'b1) rsp_seen++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checkOutput("rsp_valid", rsp_valid, 1);
            checkOutput("rsp_id", rsp_id, sb[0].id);
            checkOutput("rsp_data", rsp_data, sb[0].data);
            void'(sb.pop_front());
        end else begin
            checkOutput("rsp_valid_quiet", rsp_valid, 0);
        end
`ifdef SPRITE_ARB_STATS_EN
        checkOutput("stall_count", stall_count, m_stall);
        if (clr) m_stall = 0;
        else if (((r & ~g1h) != '0) && m_stall < 65535) m_stall++;
`endif
        m_last_gnt = g1h;
        if (g >= 0) begin
            ga = int'(a[g*ADDR_W +: ADDR_W]);
            sb.push_back('{due: cyc + 2, id: g, data: rom_mem[ga]});
            m_last_addr = ga;
            if (g > 0) m_ptr = (g % (NUM_REQ - 1)) + 1;
        end
    endtask

    task automatic doReset();
        @(posedge vga_clk);
        #1;
        req      = '0;
        req_addr = '0;
        stat_clr = 1'b0;
        reset_n  = 1'b0;
        @(negedge vga_clk);
        checkOutput("rst_rom_address", rom_address, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_idle", idle, 1);
`ifdef SPRITE_ARB_STATS_EN
        checkOutput("rst_stall_count", stall_count, 0);
`endif
        @(negedge vga_clk);
        reset_n = 1'b1;
        sb.delete();
        m_ptr       = 1;
        m_last_addr = 0;
        m_stall     = 0;
        m_last_gnt  = '0;
    endtask

    initial begin
        logic [NUM_REQ-1:0] cur_req;
        int cur_addr [NUM_REQ];
        int base;
        int rr_exp [6];

        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        stat_clr = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);

        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};
        tbl[2]  = '{4'b0000, 4'b0000};
        tbl[3]  = '{4'b1110, 4'b1000};
        tbl[4]  = '{4'b1110, 4'b0010};
        tbl[5]  = '{4'b1110, 4'b0100};
        tbl[6]  = '{4'b0011, 4'b0001};
        tbl[7]  = '{4'b0010, 4'b0010};
        tbl[8]  = '{4'b1010, 4'b1000};
        tbl[9]  = '{4'b0101, 4'b0001};
        tbl[10] = '{4'b0100, 4'b0100};
        tbl[11] = '{4'b0010, 4'b0010};
        tbl[12] = '{4'b0000, 4'b0000};

        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].req, packAddr(5, 111, 222, 333), 1'b0);
            checkOutput("tbl_gnt", gnt, tbl[i].exp_gnt);
        end
        applyStimulus('0, '0, 1'b0);
        applyStimulus('0, '0, 1'b0);

        // Single read from requester 2
        doReset();
        applyStimulus(4'b0100, packAddr(0, 0, 37, 0), 1'b0);
        checkOutput("single_gnt", gnt, 4'b0100);
        applyStimulus('0, '0, 1'b0);
        checkOutput("single_early", rsp_valid, 0);
        applyStimulus('0, '0, 1'b0);
        checkOutput("single_valid", rsp_valid, 1);
        checkOutput("single_id", rsp_id, 2);
        checkOutput("single_data", rsp_data, rom_mem[37]);
        applyStimulus('0, '0, 1'b0);
        checkOutput("single_idle", idle, 1);

        // Display priority: requester 1 locked out, pointer untouched
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0011, packAddr(1, 2, 0, 0), 1'b0);
            checkOutput("prio_gnt", gnt, 4'b0001);
        end
        applyStimulus(4'b1110, packAddr(0, 10, 20, 30), 1'b0);
        checkOutput("prio_ptr_kept", gnt, 4'b0010);
`ifdef SPRITE_ARB_STATS_EN
        checkOutput("prio_stalls", stall_count, 5);
`endif

        // Round-robin among 1..3
        doReset();
        rr_exp = '{1, 2, 3, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1110, packAddr(0, 10, 20, 30), 1'b0);
            checkOutput("rr_order", gnt, 1 << rr_exp[i]);
        end
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0);

        // Back-to-back addresses 0..399 from requester 1
        base = rsp_seen;
        for (int k = 0; k < 400; k++) applyStimulus(4'b0010, packAddr(0, k, 0, 0), 1'b0);
        applyStimulus('0, '0, 1'b0);
        applyStimulus('0, '0, 1'b0);
        checkOutput("b2b_count", rsp_seen - base, 400);

        // Reset clears the round-robin pointer
        applyStimulus(4'b0010, packAddr(0, 7, 0, 0), 1'b0);
        doReset();
        applyStimulus(4'b1110, packAddr(0, 10, 20, 30), 1'b0);
        checkOutput("rst_ptr", gnt, 4'b0010);
        applyStimulus('0, '0, 1'b0);

        // Reset during the cycle after a grant to requester 3
        applyStimulus(4'b1000, packAddr(0, 0, 0, 55), 1'b0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, '0, 1'b0);
            checkOutput("flight_dropped", rsp_valid, 0);
        end
        checkOutput("flight_addr", rom_address, 0);
        checkOutput("flight_idle", idle, 1);

        // Randomized traffic obeying the hold-until-granted rule
        cur_req = '0;
        for (int i = 0; i < NUM_REQ; i++) cur_addr[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(cur_req[i] && !m_last_gnt[i])) begin
                    cur_req[i]  = ($urandom_range(0, 99) < ((i == 0) ? 20 : 45));
                    cur_addr[i] = $urandom_range(0, 399);
                end
            end
            applyStimulus(cur_req, packAddr(cur_addr[0], cur_addr[1], cur_addr[2], cur_addr[3]),
                          ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0);

`ifdef SPRITE_ARB_STATS_EN
        // Saturation, then clear while stalling
        doReset();
        for (int i = 0; i < 70000; i++) applyStimulus(4'b0011, packAddr(3, 4, 0, 0), 1'b0);
        checkOutput("stat_sat", stall_count, 16'hFFFF);
        applyStimulus(4'b0011, packAddr(3, 4, 0, 0), 1'b1);
        applyStimulus(4'b0011, packAddr(3, 4, 0, 0), 1'b0);
        checkOutput("stat_cleared", stall_count, 0);
        applyStimulus(4'b0011, packAddr(3, 4, 0, 0), 1'b0);
        checkOutput("stat_resume", stall_count, 1);
        applyStimulus('0, '0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one sprite ROM (registered address in, palette index out, read on the falling edge of `vga_clk`) among several requesters: the pixel-display path plus the Pac-Man and ghost sprite engines. Requester 0 (display) has absolute priority; the remaining requesters are served round-robin. The block owns the ROM address, tags each read with its requester ID, and returns the palette index two rising edges after the grant. It sits between the sprite engines and the ROM/palette pair.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8); requester 0 is the display path.
- `ADDR_W`, 9: ROM address width (400-entry 20x20 sprite).
- `DATA_W`, 5: ROM data (palette index) width.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

- `vga_clk` in 1: single clock; all registers on the rising edge. The ROM is clocked by `~vga_clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester read request, level, held until granted.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; slice i belongs to requester i.
- `gnt` out NUM_REQ: one-hot grant, combinational in the cycle it is given; all zero when `req`=0.
- `rom_address` out ADDR_W: registered ROM address.
- `rom_q` in DATA_W: ROM output.
- `rsp_valid` out 1: one-cycle pulse; `rsp_data`/`rsp_id` are valid.
- `rsp_id` out ID_W: requester the response belongs to.
- `rsp_data` out DATA_W: palette index read.
- `idle` out 1: high when no read is issued or in flight and `req`=0.
- `stat_clr` in 1: synchronous clear of `stall_count` (present only with the stats macro).
- `stall_count` out 16: saturating stall counter (present only with the stats macro).

## Operation
- Arbitration is combinational on `req` in each cycle:
  - If `req[0]`=1, requester 0 is granted.
  - Otherwise the first requesting index at or after `rr_ptr` is granted, searching over 1..NUM_REQ-1 with wrap-around.
- `rr_ptr` resets to 1. It moves to (granted index + 1), wrapping NUM_REQ to 1, only when a non-zero requester is granted. A grant to requester 0 leaves it unchanged.
- At most one grant per cycle; throughput is one read per cycle with no bubbles.
- The pipeline has two stages:
  - Issue: `rom_address`, `iss_v` and `iss_id` are registered.
  - Response: `rsp_data` captures `rom_q`, `rsp_id` takes `iss_id`, and `rsp_valid` takes `iss_v`.
- A requester that is not granted keeps `req` and `req_addr` stable. On `gnt[i]` it may drop `req` or present the next address in the following cycle.
- Starvation of requesters 1..N-1 under continuous `req[0]` is by design: the display path never waits.
- When no grant is given, `rom_address` holds its previous value and `iss_v` is 0.

## Timing
- Cycle c: `req[i]`=1 and arbitration picks i, so `gnt[i]`=1 during c.
- Rising edge ending c: `rom_address` takes `req_addr[i]`, `iss_v`=1, `iss_id`=i.
- Falling edge inside c+1: the ROM samples the address.
- Rising edge ending c+1: `rsp_valid`=1, `rsp_id`=i, `rsp_data`=ROM[addr]; these are visible throughout c+2.
- Latency is 2 rising edges from grant to response, fixed.
- Reset values: `rom_address`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `iss_v`=0, `rr_ptr`=1, `idle`=1, `stall_count`=0.
- Reset asserted mid-operation discards in-flight reads. No `rsp_valid` is produced for them after reset releases.
- `gnt` is purely combinational and is not gated by reset. Requesters must ignore it while `reset_n`=0.

## Configuration
- `SPRITE_ARB_STATS_EN` defined:
  - `stat_clr` and `stall_count` exist.
  - `stall_count` increments by 1 each cycle in which at least one `req` bit is high without a grant, and saturates at 16'hFFFF.
  - `stat_clr`=1 sets the count to 0 on the next edge; clear wins over increment.
- `SPRITE_ARB_STATS_EN` undefined: both ports and the counter are absent, and the arbitration/pipeline behaviour is identical.

## Test plan
- Single read: only `req[2]`, addr 37 → `gnt`=4'b0100 in the same cycle; `rsp_valid` two edges later with `rsp_id`=2 and `rsp_data`=ROM[37]; `idle` returns to 1 afterwards.
- Priority: `req[0]` and `req[1]` held for 5 cycles → `gnt[0]` every cycle, `gnt[1]` never, `rr_ptr` stays 1. With stats on, `stall_count`=5.
- Round-robin: `req[1]`, `req[2]`, `req[3]` held with addrs 10/20/30 → grant order 1,2,3,1,2,3. Responses arrive in the same order with the matching data, one per cycle.
- Back-to-back: requester 1 presents addrs 0..399 on consecutive cycles → 400 consecutive `rsp_valid` pulses in address order, none missing.
- Reset mid-flight: grant to requester 3 at cycle c, `reset_n` low during c+1 → no `rsp_valid` afterwards; all outputs at reset values and `rr_ptr`=1 after release.
- Stats clear/saturation: force 70000 stalled cycles → `stall_count`=16'hFFFF. Assert `stat_clr` while stalling → 0 next edge, then counting resumes at 1.
